// File: rtl/satd_pkg.sv
// Shared widths, FSM state encoding and row type for the 4x4 Hadamard SATD block.
package satd_pkg;

  localparam int DW_DEFAULT = 9;
  localparam int ROW_W      = DW_DEFAULT + 2;
  localparam int COL_W      = DW_DEFAULT + 4;
  localparam int ABS_W      = DW_DEFAULT + 3;
  localparam int SW_DEFAULT = DW_DEFAULT + 7;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_COL  = 1'b1
  } state_t;

  typedef logic [3:0][DW_DEFAULT-1:0] row_t;

endpackage

// File: rtl/hadamard4.sv
// Combinational 4-point Hadamard butterfly; IW-bit signed inputs, IW+2-bit signed outputs.
module hadamard4
  import satd_pkg::*;
#(
  parameter int IW = DW_DEFAULT
) (
  input  logic [3:0][IW-1:0]   x_i,
  output logic [3:0][IW+1:0]   y_o
);

  logic signed [IW+1:0] e0, e1, e2, e3;
  logic signed [IW+1:0] s0, s1, s2, s3;

  // Sign-extend up front so every sum is evaluated at the full output width.
  assign e0 = {{2{x_i[0][IW-1]}}, x_i[0]};
  assign e1 = {{2{x_i[1][IW-1]}}, x_i[1]};
  assign e2 = {{2{x_i[2][IW-1]}}, x_i[2]};
  assign e3 = {{2{x_i[3][IW-1]}}, x_i[3]};

  assign s0 = e0 + e1;
  assign s1 = e0 - e1;
  assign s2 = e2 + e3;
  assign s3 = e2 - e3;

  assign y_o[0] = s0 + s2;
  assign y_o[1] = s1 + s3;
  assign y_o[2] = s0 - s2;
  assign y_o[3] = s1 - s3;

endmodule

// File: rtl/satd_hadamard4x4.sv
// 4x4 Hadamard SATD: rows transformed on entry, columns from a transpose buffer.
// satd/out_valid appear 4 enabled cycles after the last row; in_ready drops while columns are processed.
module satd_hadamard4x4
  import satd_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int SW = DW + 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [4*DW-1:0]   diff_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SW-1:0]     satd,
  output logic              out_valid
);

  localparam int RW = DW + 2;
  localparam int CW = DW + 4;

  state_t                  state_q, state_d;
  logic [1:0]              row_cnt_q, row_cnt_d;
  logic [1:0]              col_cnt_q, col_cnt_d;
  logic [SW-1:0]           acc_q, acc_d;
  logic [SW-1:0]           satd_q, satd_d;
  logic                    out_valid_q, out_valid_d;
  logic [3:0][3:0][RW-1:0] buf_q, buf_d;

  logic [3:0][DW-1:0]      row_x;
  logic [3:0][RW-1:0]      row_y;
  logic [3:0][RW-1:0]      col_x;
  logic [3:0][CW-1:0]      col_y;
  logic [SW-1:0]           col_sum;

  assign row_x = diff_in;

  hadamard4 #(.IW(DW)) u_row_pass (
    .x_i (row_x),
    .y_o (row_y)
  );

  always_comb begin
    col_x = '0;
    for (int r = 0; r < 4; r++) begin
      col_x[r] = buf_q[r][col_cnt_q];
    end
  end

  hadamard4 #(.IW(RW)) u_col_pass (
    .x_i (col_x),
    .y_o (col_y)
  );

  // Column coefficients stay within +/-16*255, so negation never overflows CW bits.
  always_comb begin : abs_sum
    logic [CW-1:0] mag;
    mag     = '0;
    col_sum = '0;
    for (int i = 0; i < 4; i++) begin
      mag     = col_y[i][CW-1] ? CW'(-col_y[i]) : col_y[i];
      col_sum = col_sum + SW'(mag);
    end
  end

  assign in_ready  = enable && (state_q == ST_LOAD);
  assign satd      = satd_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    acc_d       = acc_q;
    satd_d      = satd_q;
    out_valid_d = out_valid_q;
    buf_d       = buf_q;

    if (enable) begin
      out_valid_d = 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            buf_d[row_cnt_q] = row_y;
            row_cnt_d        = row_cnt_q + 2'd1;
            if (row_cnt_q == 2'd3) begin
              state_d   = ST_COL;
              col_cnt_d = 2'd0;
              acc_d     = '0;
            end
          end
        end
        ST_COL: begin
          acc_d     = acc_q + col_sum;
          col_cnt_d = col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            satd_d      = acc_q + col_sum;
            out_valid_d = 1'b1;
            state_d     = ST_LOAD;
            row_cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= 2'd0;
      col_cnt_q   <= 2'd0;
      acc_q       <= '0;
      satd_q      <= '0;
      out_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      acc_q       <= acc_d;
      satd_q      <= satd_d;
      out_valid_q <= out_valid_d;
      buf_q       <= buf_d;
    end
  end

endmodule
